mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the RV32I-subset core. Sits directly beside the multicycle datapath: consumes its `op`, `f3`, `f7`, `z`, `s` outputs and drives every datapath enable and select. A state machine sequences fetch, decode, execute, memory and writeback per instruction. Opcode and function fields are captured internally at fetch, because the datapath exports them straight from the memory read port.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input 7: opcode from the memory read port.
- `f3` input 3: funct3 from the memory read port.
- `f7` input 7: funct7 from the memory read port.
- `z` input 1: ALU zero flag.
- `s` input 1: ALU result bit 31.
- `PC_update`, `Adr_src`, `mem_wr`, `reg_wr`, `IR_wr` output 1 each: datapath enables and address select.
- `A_src`, `B_src`, `result_src` output 2 each: mux selects.
- `imm_src`, `ALU_op` output 3 each: immediate format and ALU operation.
- `halted` output 1: illegal-opcode halt indicator.

## Operation
- Encodings:
  - `A_src`: 00 PC, 01 oldPC, 10 A-reg, 11 zero.
  - `B_src`: 00 B-reg, 01 imm, 10 four.
  - `result_src`: 00 ALUOut-reg, 01 MDR, 10 ALU direct.
  - `imm_src`: 000 I, 001 S, 010 B, 011 J, 100 U.
  - `ALU_op`: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor.
- Supported instructions:
  - R: add, sub, and, or, slt, xor.
  - I: addi, andi, ori, slti, xori.
  - Memory and control: lw, sw, beq, bne, blt, bge, jal, jalr, lui.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Controls: Adr_src=0, IR_wr=1, A=PC, B=four, add, result_src=10, PC_update=1.
  - On this edge, latch op/f3/f7 into internal registers.
- DECODE:
  - Controls: A=oldPC, B=imm, add (ALUOut ← branch/jal target).
  - imm_src = J for jal, otherwise B.
  - Next state is selected by the latched op.
- MEM_ADR (lw/sw): A=A-reg, B=imm, add. imm_src = I for lw, S for sw.
- MEM_READ: Adr_src=1, result_src=00.
- MEM_WB: reg_wr=1, result_src=01.
- MEM_WRITE: Adr_src=1, result_src=00, mem_wr=1.
- EXEC_R: A=A-reg, B=B-reg; ALU_op from `alu_decoder`.
- EXEC_I: A=A-reg, B=imm, imm_src=I; ALU_op from `alu_decoder`, with f7 ignored.
- ALU_WB: reg_wr=1, result_src=00.
- BRANCH:
  - Controls: A=A-reg, B=B-reg, sub, result_src=00.
  - PC_update (Mealy) is asserted as follows:
    - beq: z=1.
    - bne: z=0.
    - blt: s=1.
    - bge: s=0.
  - Signed overflow is ignored.
- JAL: result_src=00, PC_update=1; A=oldPC, B=four, add. Next state ALU_WB.
- JALR1: A=A-reg, B=imm(I), add, result_src=10, PC_update=1. Next state JALR2.
- JALR2: A=oldPC, B=four, add. Next state ALU_WB.
- LUI: A=zero, B=imm(U), add. Next state ALU_WB.
- Terminal states: MEM_WB, MEM_WRITE, ALU_WB and BRANCH return to FETCH.

## Timing
- Cycles per instruction:
  - branch: 3.
  - R, I-ALU, sw, jal, lui: 4.
  - lw, jalr: 5.
- All outputs are combinational from state and latched fields. The only exception is PC_update in BRANCH, which also depends on z and s.
- Reset:
  - While rst_n=0, every output is 0 and halted=0.
  - State is FETCH and the latched fields are 0.
  - The first edge after release executes FETCH.
- Reset asserted mid-instruction aborts it immediately; no partial writes occur after assertion.
- Field latch updates only in FETCH. Changes on `op`/`f3`/`f7` in other states have no effect.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode or funct combination in DECODE enters HALT.
  - In HALT, all enables are 0 and halted=1 until reset.
- `MC_CTRL_ILLEGAL_TRAP_EN` undefined:
  - An unsupported instruction is a NOP: DECODE returns to FETCH.
  - halted is tied to 0.

## Structure
- Package `mc_pkg` holds:
  - state enum.
  - opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111).
  - A_src, B_src, result_src, imm_src and ALU_op encodings.
- One sub-module, `alu_decoder`: combinational mapping of instruction class + f3 + f7[5] → ALU_op.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; first cycle after release shows IR_wr=1, PC_update=1, B_src=10.
- R-type sub (f7=0100000, f3=000) → states FETCH, DECODE, EXEC_R (ALU_op=001), ALU_WB (reg_wr=1); 4 cycles.
- lw → MEM_READ has Adr_src=1; MEM_WB has result_src=01, reg_wr=1; 5 cycles total.
- beq: with z=1, PC_update=1 in BRANCH; with z=0, PC_update=0. bge with s=1 → no update.
- `op` changed to 0100011 on the memory port during EXEC_R → execution still completes as R-type.
- Opcode 1111111:
  - with `MC_CTRL_ILLEGAL_TRAP_EN`: halted=1 and no enables until rst_n=0.
  - without: next cycle is FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle RV32I-subset control unit.
// The optional illegal-instruction trap is enabled with MC_CTRL_ILLEGAL_TRAP_EN.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADR   = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_EXEC_I    = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JAL       = 4'd10,
    ST_JALR1     = 4'd11,
    ST_JALR2     = 4'd12,
    ST_LUI       = 4'd13,
    ST_HALT      = 4'd14
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    A_PC    = 2'b00,
    A_OLDPC = 2'b01,
    A_REG   = 2'b10,
    A_ZERO  = 2'b11
  } a_src_e;

  typedef enum logic [1:0] {
    B_REG  = 2'b00,
    B_IMM  = 2'b01,
    B_FOUR = 2'b10
  } b_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_MDR    = 2'b01,
    RES_ALU    = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_XOR = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic        pc_update;
    logic        adr_src;
    logic        mem_wr;
    logic        reg_wr;
    logic        ir_wr;
    a_src_e      a_src;
    b_src_e      b_src;
    result_src_e result_src;
    imm_src_e    imm_src;
    alu_op_e     alu_op;
    logic        halted;
  } ctrl_t;

  // Branch decision from the subtraction flags; overflow is deliberately ignored.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic s);
    logic taken;
    case (f3)
      3'b000:  taken = z;
      3'b001:  taken = ~z;
      3'b100:  taken = s;
      3'b101:  taken = ~s;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decode from instruction class, funct3 and funct7 bit 5.
module alu_decoder
  import mc_pkg::*;
(
  input  logic    is_r_i,
  input  logic [2:0] f3_i,
  input  logic    f7_5_i,
  output alu_op_e alu_op_o
);

  // funct7[5] selects subtract only for R-type; immediates never subtract.
  always_comb begin
    alu_op_o = ALU_ADD;
    case (f3_i)
      3'b000: begin
        if (is_r_i && f7_5_i) alu_op_o = ALU_SUB;
        else                  alu_op_o = ALU_ADD;
      end
      3'b010:  alu_op_o = ALU_SLT;
      3'b100:  alu_op_o = ALU_XOR;
      3'b110:  alu_op_o = ALU_OR;
      3'b111:  alu_op_o = ALU_AND;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM driving every datapath enable/select of the RV32I-subset core.
// Define MC_CTRL_ILLEGAL_TRAP_EN to halt on unsupported instructions instead of skipping them.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       z,
  input  logic       s,
  output logic       PC_update,
  output logic       Adr_src,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic       IR_wr,
  output logic [1:0] A_src,
  output logic [1:0] B_src,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [2:0] ALU_op,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [6:0] op_q, f7_q;
  logic [2:0] f3_q;
  ctrl_t      ctrl;
  alu_op_e    alu_dec_op;
  logic       is_r;
  logic       alu_f3_ok;
  logic       legal;

  // State register; instruction fields are captured only while fetching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
      f7_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) begin
        op_q <= op;
        f3_q <= f3;
        f7_q <= f7;
      end
    end
  end

  assign is_r = (op_q == OP_R);

  alu_decoder u_alu_dec (
    .is_r_i   (is_r),
    .f3_i     (f3_q),
    .f7_5_i   (f7_q[5]),
    .alu_op_o (alu_dec_op)
  );

  // Legality of the latched instruction, used by DECODE to skip or trap.
  always_comb begin
    alu_f3_ok = (f3_q == 3'b000) || (f3_q == 3'b010) || (f3_q == 3'b100) ||
                (f3_q == 3'b110) || (f3_q == 3'b111);
    case (op_q)
      OP_R:      legal = alu_f3_ok && ((f7_q == 7'b0000000) ||
                                       ((f7_q == 7'b0100000) && (f3_q == 3'b000)));
      OP_I:      legal = alu_f3_ok;
      OP_LOAD:   legal = (f3_q == 3'b010);
      OP_STORE:  legal = (f3_q == 3'b010);
      OP_BRANCH: legal = (f3_q == 3'b000) || (f3_q == 3'b001) ||
                         (f3_q == 3'b100) || (f3_q == 3'b101);
      OP_JAL:    legal = 1'b1;
      OP_JALR:   legal = (f3_q == 3'b000);
      OP_LUI:    legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  // Next-state and control decode; only BRANCH looks at the live ALU flags.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.ir_wr      = 1'b1;
        ctrl.pc_update  = 1'b1;
        ctrl.a_src      = A_PC;
        ctrl.b_src      = B_FOUR;
        ctrl.result_src = RES_ALU;
        state_d         = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl.a_src = A_OLDPC;
        ctrl.b_src = B_IMM;
        if (op_q == OP_JAL) ctrl.imm_src = IMM_J;
        else                ctrl.imm_src = IMM_B;
        if (!legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          case (op_q)
            OP_R:      state_d = ST_EXEC_R;
            OP_I:      state_d = ST_EXEC_I;
            OP_LOAD:   state_d = ST_MEM_ADR;
            OP_STORE:  state_d = ST_MEM_ADR;
            OP_BRANCH: state_d = ST_BRANCH;
            OP_JAL:    state_d = ST_JAL;
            OP_JALR:   state_d = ST_JALR1;
            OP_LUI:    state_d = ST_LUI;
            default:   state_d = ST_FETCH;
          endcase
        end
      end
      ST_MEM_ADR: begin
        ctrl.a_src = A_REG;
        ctrl.b_src = B_IMM;
        if (op_q == OP_LOAD) begin
          ctrl.imm_src = IMM_I;
          state_d      = ST_MEM_READ;
        end else begin
          ctrl.imm_src = IMM_S;
          state_d      = ST_MEM_WRITE;
        end
      end
      ST_MEM_READ: begin
        ctrl.adr_src = 1'b1;
        state_d      = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.result_src = RES_MDR;
        state_d         = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_wr  = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_EXEC_R: begin
        ctrl.a_src  = A_REG;
        ctrl.b_src  = B_REG;
        ctrl.alu_op = alu_dec_op;
        state_d     = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        ctrl.a_src   = A_REG;
        ctrl.b_src   = B_IMM;
        ctrl.imm_src = IMM_I;
        ctrl.alu_op  = alu_dec_op;
        state_d      = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        ctrl.reg_wr = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl.a_src     = A_REG;
        ctrl.b_src     = B_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_update = branch_taken(f3_q, z, s);
        state_d        = ST_FETCH;
      end
      ST_JAL: begin
        ctrl.pc_update = 1'b1;
        ctrl.a_src     = A_OLDPC;
        ctrl.b_src     = B_FOUR;
        state_d        = ST_ALU_WB;
      end
      ST_JALR1: begin
        ctrl.a_src      = A_REG;
        ctrl.b_src      = B_IMM;
        ctrl.imm_src    = IMM_I;
        ctrl.result_src = RES_ALU;
        ctrl.pc_update  = 1'b1;
        state_d         = ST_JALR2;
      end
      ST_JALR2: begin
        ctrl.a_src = A_OLDPC;
        ctrl.b_src = B_FOUR;
        state_d    = ST_ALU_WB;
      end
      ST_LUI: begin
        ctrl.a_src   = A_ZERO;
        ctrl.b_src   = B_IMM;
        ctrl.imm_src = IMM_U;
        state_d      = ST_ALU_WB;
      end
      ST_HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ctrl.halted = 1'b1;
        state_d     = ST_HALT;
`else
        state_d     = ST_FETCH;
`endif
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset gates outputs combinationally so an abort cannot leak a write.
  assign PC_update  = rst_n & ctrl.pc_update;
  assign Adr_src    = rst_n & ctrl.adr_src;
  assign mem_wr     = rst_n & ctrl.mem_wr;
  assign reg_wr     = rst_n & ctrl.reg_wr;
  assign IR_wr      = rst_n & ctrl.ir_wr;
  assign A_src      = rst_n ? ctrl.a_src      : 2'b00;
  assign B_src      = rst_n ? ctrl.b_src      : 2'b00;
  assign result_src = rst_n ? ctrl.result_src : 2'b00;
  assign imm_src    = rst_n ? ctrl.imm_src    : 3'b000;
  assign ALU_op     = rst_n ? ctrl.alu_op     : 3'b000;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign halted     = rst_n & ctrl.halted;
`else
  assign halted     = 1'b0;
`endif

endmodule
